// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the display scheduler.
//   state_e     : view state machine encoding (RUN / SET / ERR)
//   SRC_*       : disp_src codes presented to the scanner side
//   BLANK       : digit code that the scanner renders as an unlit digit
//   ERR_LETTER  : digit code rendered as the letter 'E'
//   seg_frame_t : four latched digit codes, leftmost digit in d3
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_SET = 2'b01,
    ST_ERR = 2'b10
  } state_e;

  localparam logic [1:0] SRC_RUN = 2'b00;
  localparam logic [1:0] SRC_SET = 2'b01;
  localparam logic [1:0] SRC_ERR = 2'b10;

  localparam logic [3:0] BLANK      = 4'hF;
  localparam logic [3:0] ERR_LETTER = 4'hE;

  // Index of the last digit in a scan frame
  localparam logic [1:0] DIGIT_LAST = 2'd3;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } seg_frame_t;

  // Map a view state onto the disp_src code the scanner sees
  function automatic logic [1:0] src_of(input state_e s);
    case (s)
      ST_SET:  return SRC_SET;
      ST_ERR:  return SRC_ERR;
      default: return SRC_RUN;
    endcase
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler and digit counter.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   scan_tick_o  : one-cycle pulse every SCAN_DIV clocks (count == SCAN_DIV-1)
//   frame_end_o  : scan_tick_o coinciding with the last digit of the frame
module scan_prescaler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic scan_tick_o,
  output logic frame_end_o
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic             tick_q, tick_d;
  logic             fe_q, fe_d;

  // Pulses are decoded from the next count so they are registered yet
  // still high exactly in the cycle the count sits at its last value.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    dig_d  = tick_q ? dig_q + 2'd1 : dig_q;
    tick_d = (cnt_d == CNT_LAST);
    fe_d   = tick_d && (dig_d == DIGIT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dig_q  <= '0;
      tick_q <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      tick_q <= tick_d;
      fe_q   <= fe_d;
    end
  end

  assign scan_tick_o = tick_q;
  assign frame_end_o = fe_q;

endmodule

// File: rtl/display_scheduler.sv
// Four-digit display scheduler: picks the RUN / SET / ERR view, blinks the
// error view and latches a tear-free frame for the scanner at frame ends.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   run_digits_i   : countdown view, [15:12] leftmost digit
//   set_digits_i   : user-setting view, same packing
//   set_req_i      : one-cycle pulse per user edit
//   err_req_i      : error condition level
//   err_code_i     : error number shown in the ERR view
//   scan_tick_o    : scanner clock enable
//   seg3_o..seg0_o : latched digit codes, 4'hF = blank
//   disp_src_o     : view currently on the display (00 RUN, 01 SET, 10 ERR)
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_HALF = 250,
  parameter int unsigned SET_HOLD   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] run_digits_i,
  input  logic [15:0] set_digits_i,
  input  logic        set_req_i,
  input  logic        err_req_i,
  input  logic [3:0]  err_code_i,
  output logic        scan_tick_o,
  output logic [3:0]  seg3_o,
  output logic [3:0]  seg2_o,
  output logic [3:0]  seg1_o,
  output logic [3:0]  seg0_o,
  output logic [1:0]  disp_src_o
);

  localparam int unsigned HOLD_W  = $clog2(SET_HOLD + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(SET_HOLD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic frame_end;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_tick_o (scan_tick_o),
    .frame_end_o (frame_end)
  );

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_blank_q, blink_blank_d;
  seg_frame_t         frame_q, frame_d;
  logic [1:0]         src_q, src_d;

  // Next state, hold/blink counters and frame latch
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    blink_cnt_d   = blink_cnt_q;
    blink_blank_d = blink_blank_q;
    frame_d       = frame_q;
    src_d         = src_q;

    // The frame shows the view that was active during the frame just
    // scanned, so a state change appears one boundary later.
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_blank_d = ~blink_blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end

      case (state_q)
        ST_SET: frame_d = seg_frame_t'(set_digits_i);
        ST_ERR: begin
          if (blink_blank_q) begin
            frame_d = '{default: BLANK};
          end else begin
            frame_d = '{d3: ERR_LETTER, d2: BLANK, d1: BLANK, d0: err_code_i};
          end
        end
        default: frame_d = seg_frame_t'(run_digits_i);
      endcase
      src_d = src_of(state_q);
    end

    // Error dominates; entering it restarts the blink on the visible phase
    if (err_req_i) begin
      state_d = ST_ERR;
      hold_d  = '0;
      if (state_q != ST_ERR) begin
        blink_cnt_d   = '0;
        blink_blank_d = 1'b0;
      end
    end else if (state_q == ST_ERR) begin
      state_d = ST_RUN;
    end else if (set_req_i) begin
      state_d = ST_SET;
      hold_d  = HOLD_LOAD;
    end else if ((state_q == ST_SET) && frame_end) begin
      hold_d = hold_q - HOLD_W'(1);
      if (hold_d == '0) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      hold_q        <= '0;
      blink_cnt_q   <= '0;
      blink_blank_q <= 1'b0;
      frame_q       <= '{default: BLANK};
      src_q         <= SRC_RUN;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_blank_q <= blink_blank_d;
      frame_q       <= frame_d;
      src_q         <= src_d;
    end
  end

  assign seg3_o     = frame_q.d3;
  assign seg2_o     = frame_q.d2;
  assign seg1_o     = frame_q.d1;
  assign seg0_o     = frame_q.d0;
  assign disp_src_o = src_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: directed scenarios plus random
// traffic, compared every cycle against a cycle-count based view model.
module tb_display_scheduler;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BH    = 2;
  localparam int unsigned SH    = 3;
  localparam int unsigned FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] run_digits = '0;
  logic [15:0] set_digits = '0;
  logic        set_req = 1'b0;
  logic        err_req = 1'b0;
  logic [3:0]  err_code = '0;
  logic        scan_tick;
  logic [3:0]  seg3, seg2, seg1, seg0;
  logic [1:0]  disp_src;

  always #5 clk = ~clk;

  display_scheduler #(
    .SCAN_DIV   (DIV),
    .BLINK_HALF (BH),
    .SET_HOLD   (SH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_digits_i (run_digits),
    .set_digits_i (set_digits),
    .set_req_i    (set_req),
    .err_req_i    (err_req),
    .err_code_i   (err_code),
    .scan_tick_o  (scan_tick),
    .seg3_o       (seg3),
    .seg2_o       (seg2),
    .seg1_o       (seg1),
    .seg0_o       (seg0),
    .disp_src_o   (disp_src)
  );

  int n_total = 0;
  int n_bad   = 0;
  int set_cycles = 0;

  // Reference model: views 0 RUN, 1 SET, 2 ERR
  int          m_cyc;
  int          m_view;
  int          m_hold;
  int          m_err_frames;
  int          m_src;
  logic [15:0] m_seg;

  logic [15:0] blink_exp [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] segs();
    return {seg3, seg2, seg1, seg0};
  endfunction

  task automatic m_reset();
    m_cyc        = 0;
    m_view       = 0;
    m_hold       = 0;
    m_err_frames = 0;
    m_src        = 0;
    m_seg        = 16'hFFFF;
  endtask

  // One clock of the model, using the inputs present at the edge
  task automatic m_step();
    bit fe;
    fe = (m_cyc % FRAME) == (FRAME - 1);
    if (fe) begin
      m_src = m_view;
      if (m_view == 1) m_seg = set_digits;
      else if (m_view == 2)
        m_seg = (((m_err_frames / BH) % 2) == 0) ? {4'hE, 4'hF, 4'hF, err_code} : 16'hFFFF;
      else m_seg = run_digits;
      if (m_view == 2) m_err_frames++;
    end
    if (err_req) begin
      if (m_view != 2) m_err_frames = 0;
      m_view = 2;
      m_hold = 0;
    end else if (m_view == 2) begin
      m_view = 0;
    end else if (set_req) begin
      m_view = 1;
      m_hold = SH;
    end else if (m_view == 1 && fe) begin
      m_hold--;
      if (m_hold == 0) m_view = 0;
    end
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("scan_tick", 32'(scan_tick), 32'((m_cyc % DIV) == (DIV - 1)));
    chk("segs", 32'(segs()), 32'(m_seg));
    chk("disp_src", 32'(disp_src), 32'(m_src));
    if (disp_src == 2'b01) set_cycles++;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_set();
    set_req = 1'b1;
    step();
    set_req = 1'b0;
  endtask

  // Move to a point four cycles into a frame
  task automatic align();
    while ((m_cyc % FRAME) != 4) step();
  endtask

  // Called at a falling edge; asserts reset, checks, releases one cycle later
  task automatic do_reset();
    rst_n   = 1'b0;
    set_req = 1'b0;
    err_req = 1'b0;
    #1;
    chk("rst_tick", 32'(scan_tick), 32'(0));
    chk("rst_segs", 32'(segs()), 32'hFFFF);
    chk("rst_src", 32'(disp_src), 32'(0));
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    blink_exp[0] = 16'hEFF7;
    blink_exp[1] = 16'hEFF7;
    blink_exp[2] = 16'hFFFF;
    blink_exp[3] = 16'hFFFF;
    blink_exp[4] = 16'hEFF7;
    blink_exp[5] = 16'hEFF7;

    m_reset();
    repeat (2) @(negedge clk);

    // First frame after reset shows run digits at the 16th clock
    run_digits = 16'h1234;
    do_reset();
    step_n(15);
    chk("pre_frame", 32'(segs()), 32'hFFFF);
    step();
    chk("first_frame", 32'(segs()), 32'h1234);
    chk("first_src", 32'(disp_src), 32'(0));

    // Mid-frame change is held off until the next boundary
    step_n(5);
    run_digits = 16'h5678;
    step_n(10);
    chk("no_tear", 32'(segs()), 32'h1234);
    step();
    chk("next_frame", 32'(segs()), 32'h5678);

    // Single edit: SET for exactly three frames
    set_digits = 16'h0930;
    align();
    set_cycles = 0;
    pulse_set();
    step_n(5 * FRAME);
    chk("set_frames", 32'(set_cycles), 32'(3 * FRAME));

    // Second edit during SET frame 2 extends by three frames after it
    align();
    set_cycles = 0;
    pulse_set();
    step_n(15);
    pulse_set();
    chk("set_view", 32'(segs()), 32'h0930);
    step_n(6 * FRAME);
    chk("set_extend", 32'(set_cycles), 32'(4 * FRAME));

    // Error raised during SET: blink two on, two off; ignore edits; exit to RUN
    align();
    pulse_set();
    step_n(15);
    err_code = 4'h7;
    err_req  = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < ((i == 0) ? 11 : 16); j++) begin
        set_req = (i == 2 && j == 0);
        step();
      end
      set_req = 1'b0;
      chk($sformatf("blink%0d", i), 32'(segs()), 32'(blink_exp[i]));
    end
    err_req = 1'b0;
    set_cycles = 0;
    step_n(3 * FRAME);
    chk("err_exit_src", 32'(disp_src), 32'(0));
    chk("err_no_set", 32'(set_cycles), 32'(0));

    // set_req and err_req rising together: the edit is discarded
    align();
    err_code = 4'h3;
    set_req  = 1'b1;
    err_req  = 1'b1;
    step();
    set_req = 1'b0;
    step_n(3 * FRAME);
    chk("simul_err", 32'(disp_src), 32'(2));
    err_req = 1'b0;
    set_cycles = 0;
    step_n(3 * FRAME);
    chk("simul_no_set", 32'(set_cycles), 32'(0));
    chk("simul_src", 32'(disp_src), 32'(0));

    // Reset in the middle of SET restarts the frame cleanly
    run_digits = 16'hABCD;
    align();
    pulse_set();
    step_n(20);
    do_reset();
    step_n(15);
    chk("rst_pre", 32'(segs()), 32'hFFFF);
    step();
    chk("rst_first", 32'(segs()), 32'hABCD);
    chk("rst_first_src", 32'(disp_src), 32'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) run_digits = 16'($urandom);
      if ($urandom_range(0, 7) == 0) set_digits = 16'($urandom);
      err_code = 4'($urandom);
      set_req  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) err_req = ~err_req;
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end
    set_req = 1'b0;
    err_req = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
